// File: rtl/uf_lookup_arbiter_if.sv
// ---------------------------------------------------------------------------
// uf_lookup_arbiter_if
// Bundles the signals between the shared membership-function ROM lookup
// arbiter, its requesters and the ROM itself.
//
//   req        requester -> arbiter  per-requester level request, held until ack
//   req_addr   requester -> arbiter  per-requester ROM address, [8i+7:8i]
//   rom_data   ROM       -> arbiter  ROM registered output (1-cycle latency)
//   rom_add    arbiter   -> ROM      ROM address
//   rd_data    arbiter   -> req      lookup result, valid while ack != 0
//   ack        arbiter   -> req      one-hot, one-cycle completion pulse
//   busy       arbiter   -> req      arbiter not idle
//   grant_id   arbiter   -> req      index of current/last granted requester
//   lookup_cnt arbiter   -> req      completed lookups, saturating
//
// master: requester/ROM side.  slave: the arbiter.
// ---------------------------------------------------------------------------
interface uf_lookup_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] req_addr;
   logic [7:0]        rom_data;
   logic [7:0]        rom_add;
   logic [7:0]        rd_data;
   logic [NREQ-1:0]   ack;
   logic              busy;
   logic [IDW-1:0]    grant_id;
   logic [15:0]       lookup_cnt;

   modport master (
      output req, req_addr, rom_data,
      input  rom_add, rd_data, ack, busy, grant_id, lookup_cnt
   );

   modport slave (
      input  req, req_addr, rom_data,
      output rom_add, rd_data, ack, busy, grant_id, lookup_cnt
   );
endinterface

// File: rtl/uf_lookup_arbiter.sv
// ---------------------------------------------------------------------------
// uf_lookup_arbiter
// Shares one membership-function lookup ROM (8-bit address, registered 8-bit
// data, one-cycle read latency) between NREQ requesters. Requests are served
// round-robin; each lookup takes IDLE/ACK -> ADDR -> DATA -> ACK, so back-to-
// back lookups complete one every 3 cycles.
//
// Ports:
//   CS    clock, all state updates on its rising edge
//   cen   asynchronous active-low reset (shared with the ROM)
//   bus   uf_lookup_arbiter_if.slave: req/req_addr/rom_data in,
//         rom_add/rd_data/ack/busy/grant_id/lookup_cnt out
// ---------------------------------------------------------------------------
module uf_lookup_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic               CS,
   input  logic               cen,
   uf_lookup_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, ACK} state_t;

   state_t            state, state_nxt;
   logic [IDW-1:0]    rr_ptr;
   logic [7:0]        rom_add_q;
   logic [7:0]        rd_data_q;
   logic [NREQ-1:0]   ack_q;
   logic [IDW-1:0]    grant_q;
   logic [15:0]       lookup_cnt_q;

   // Arbitration inputs and result
   logic [NREQ-1:0]   cand;
   logic [IDW-1:0]    start;
   logic [IDW-1:0]    idx;
   logic [IDW-1:0]    win;
   logic              found;
   logic              load;

   // In ACK the just-served requester is masked (it may still show req in
   // this cycle) and the search starts right after it; elsewhere from rr_ptr.
   // NOTE: every always_comb output gets a default first so no path leaves a
   // variable unassigned, which would infer a latch.
   always_comb begin
      cand  = bus.req;
      start = rr_ptr;
      found = 1'b0;
      win   = '0;
      idx   = '0;
      if (state == ACK) begin
         cand  = bus.req & ~(NREQ'(1) << grant_q);
         start = grant_q + 1'b1;
      end
      // NREQ is a power of two, so the IDW-bit add wraps modulo NREQ.
      for (int k = 0; k < NREQ; k++) begin
         idx = start + IDW'(k);
         if (!found && cand[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign load = found && (state == IDLE || state == ACK);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CS or negedge cen) begin
      if (!cen) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (found) state_nxt = ADDR;
         ADDR:    state_nxt = DATA;
         DATA:    state_nxt = ACK;
         ACK:     state_nxt = found ? ADDR : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CS or negedge cen) begin
      if (!cen) begin
         rom_add_q    <= '0;
         rd_data_q    <= '0;
         ack_q        <= '0;
         grant_q      <= '0;
         lookup_cnt_q <= '0;
         rr_ptr       <= '0;
      end else begin
         ack_q <= '0;
         // req_addr is sampled only here, at grant time.
         if (load) begin
            rom_add_q <= bus.req_addr[{win, 3'b000} +: 8];
            grant_q   <= win;
         end
         if (state == DATA) begin
            rd_data_q      <= bus.rom_data;
            ack_q[grant_q] <= 1'b1;
            if (lookup_cnt_q != 16'hFFFF) lookup_cnt_q <= lookup_cnt_q + 16'd1;
         end
         if (state == ACK) rr_ptr <= grant_q + 1'b1;
      end
   end

   assign bus.rom_add    = rom_add_q;
   assign bus.rd_data    = rd_data_q;
   assign bus.ack        = ack_q;
   assign bus.busy       = (state != IDLE);
   assign bus.grant_id   = grant_q;
   assign bus.lookup_cnt = lookup_cnt_q;

endmodule
